// File: rtl/fp_sgnj_arb.sv
// Two-requester round-robin arbiter around a shared FP sign-inject unit.
// One op granted per cycle into a registered valid/ready result stage.
//
// fp_sgnj ports:
//   a_i, b_i  operands (a = magnitude source, b = sign source)
//   fmt_i     0=F32, 1=F64, else illegal (zero result)
//   rm_i      0=SGNJ, 1=SGNJN, 2=SGNJX, else sign forced to 0
//   res_o     result, err_o illegal fmt/rm flag
//
// fp_sgnj_arb ports:
//   clk, rst_n             clock, async active-low reset
//   req_valid/req_ready    per-requester handshake (bit i = requester i)
//   req_data1/req_data2    operands, requester i at [64i +: 64]
//   req_fmt/req_rm/req_tag per-requester fmt, op and tag
//   o_valid/o_ready        result handshake
//   o_result/o_tag/o_src   result, its tag and issuing requester
//   o_err                  op had an illegal fmt or rm
//   cnt0/cnt1              accepted-op counters per requester

module fp_sgnj (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic [1:0]  fmt_i,
  input  logic [2:0]  rm_i,
  output logic [63:0] res_o,
  output logic        err_o
);

  logic sa;
  logic sb;
  logic s;

  always_comb begin
    sa    = 1'b0;
    sb    = 1'b0;
    s     = 1'b0;
    res_o = '0;
    err_o = (fmt_i > 2'd1) || (rm_i > 3'd2);
    case (fmt_i)
      2'd0: begin
        sa = a_i[31];
        sb = b_i[31];
      end
      2'd1: begin
        sa = a_i[63];
        sb = b_i[63];
      end
      default: ;
    endcase
    case (rm_i)
      3'd0:    s = sb;
      3'd1:    s = ~sb;
      3'd2:    s = sa ^ sb;
      default: s = 1'b0;
    endcase
    case (fmt_i)
      2'd0:    res_o = {32'h0, s, a_i[30:0]};
      2'd1:    res_o = {s, a_i[62:0]};
      default: res_o = '0;
    endcase
  end

endmodule

module fp_sgnj_arb #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [127:0]       req_data1,
  input  logic [127:0]       req_data2,
  input  logic [3:0]         req_fmt,
  input  logic [5:0]         req_rm,
  input  logic [2*TAG_W-1:0] req_tag,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [63:0]        o_result,
  output logic [TAG_W-1:0]   o_tag,
  output logic               o_src,
  output logic               o_err,
  output logic [CNT_W-1:0]   cnt0,
  output logic [CNT_W-1:0]   cnt1
);

  logic             valid_q, valid_d;
  logic [63:0]      result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             src_q, src_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             ptr_q, ptr_d;

  logic             slot;
  logic             any_v;
  logic             sel;
  logic             accept;
  logic [63:0]      op_a;
  logic [63:0]      op_b;
  logic [1:0]       op_fmt;
  logic [2:0]       op_rm;
  logic [TAG_W-1:0] op_tag;
  logic [63:0]      op_res;
  logic             op_err;

  assign slot  = !valid_q || o_ready;
  assign any_v = |req_valid;

  // Contention goes to ptr; a lone requester wins outright.
  assign sel = (&req_valid) ? ptr_q : req_valid[1];

  // Grant is gated by reset so nothing is taken while rst_n is low.
  always_comb begin
    req_ready = 2'b00;
    if (any_v && slot && rst_n) begin
      req_ready = sel ? 2'b10 : 2'b01;
    end
  end

  assign accept = |req_ready;

  assign op_a   = req_data1[64*sel +: 64];
  assign op_b   = req_data2[64*sel +: 64];
  assign op_fmt = req_fmt[2*sel +: 2];
  assign op_rm  = req_rm[3*sel +: 3];
  assign op_tag = req_tag[TAG_W*sel +: TAG_W];

  fp_sgnj u_sgnj (
    .a_i   (op_a),
    .b_i   (op_b),
    .fmt_i (op_fmt),
    .rm_i  (op_rm),
    .res_o (op_res),
    .err_o (op_err)
  );

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    tag_d    = tag_q;
    src_d    = src_q;
    err_d    = err_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    ptr_d    = ptr_q;
    if (accept) begin
      valid_d  = 1'b1;
      result_d = op_res;
      tag_d    = op_tag;
      src_d    = sel;
      err_d    = op_err;
      ptr_d    = ~sel;
      if (sel) begin
        cnt1_d = cnt1_q + CNT_W'(1);
      end else begin
        cnt0_d = cnt0_q + CNT_W'(1);
      end
    end else if (o_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      tag_q    <= '0;
      src_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
      ptr_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      tag_q    <= tag_d;
      src_q    <= src_d;
      err_q    <= err_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
      ptr_q    <= ptr_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_tag    = tag_q;
  assign o_src    = src_q;
  assign o_err    = err_q;
  assign cnt0     = cnt0_q;
  assign cnt1     = cnt1_q;

endmodule

// File: tb/tb_fp_sgnj_arb.sv
// Scoreboard bench for fp_sgnj_arb: driver pushes expected results,
// a negedge monitor pops and compares on each o_valid && o_ready.

module tb_fp_sgnj_arb;

  localparam int TAG_W = 4;
  localparam int CNT_W = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [127:0]       req_data1;
  logic [127:0]       req_data2;
  logic [3:0]         req_fmt;
  logic [5:0]         req_rm;
  logic [2*TAG_W-1:0] req_tag;
  logic               o_valid;
  logic               o_ready;
  logic [63:0]        o_result;
  logic [TAG_W-1:0]   o_tag;
  logic               o_src;
  logic               o_err;
  logic [CNT_W-1:0]   cnt0;
  logic [CNT_W-1:0]   cnt1;

  fp_sgnj_arb #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data1 (req_data1),
    .req_data2 (req_data2),
    .req_fmt   (req_fmt),
    .req_rm    (req_rm),
    .req_tag   (req_tag),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_result  (o_result),
    .o_tag     (o_tag),
    .o_src     (o_src),
    .o_err     (o_err),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]      res;
    logic [TAG_W-1:0] tag;
    logic             src;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  bit   m_valid;
  bit   m_ptr;
  int   m_cnt[2];

  logic [63:0]      A[2];
  logic [63:0]      B[2];
  logic [1:0]       F[2];
  logic [2:0]       R[2];
  logic [TAG_W-1:0] T[2];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Sign injection from the op definition: magnitude from a, sign chosen by op.
  function automatic exp_t ref_op(logic [63:0] a, logic [63:0] b,
                                  logic [1:0] fmt, logic [2:0] rm,
                                  logic [TAG_W-1:0] tag, logic src);
    exp_t e;
    int   w;
    logic sa, sbit, s;
    logic [63:0] mag;
    e.tag = tag;
    e.src = src;
    e.err = (fmt > 1) || (rm > 2);
    e.res = 64'h0;
    if (fmt <= 1) begin
      w    = (fmt == 0) ? 32 : 64;
      sa   = a[w-1];
      sbit = b[w-1];
      if (rm == 0)      s = sbit;
      else if (rm == 1) s = !sbit;
      else if (rm == 2) s = sa ^ sbit;
      else              s = 1'b0;
      mag   = a & ((64'h1 << (w - 1)) - 64'h1);
      e.res = mag | (64'(s) << (w - 1));
    end
    return e;
  endfunction

  task automatic set_op(int i, logic [63:0] a, logic [63:0] b,
                        logic [1:0] f, logic [2:0] r, logic [TAG_W-1:0] t);
    A[i] = a; B[i] = b; F[i] = f; R[i] = r; T[i] = t;
  endtask

  task automatic rand_op(int i);
    set_op(i, {$urandom, $urandom}, {$urandom, $urandom},
           ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3))
                                       : 2'($urandom_range(0, 1)),
           3'($urandom_range(0, 7) == 0 ? $urandom_range(3, 7)
                                        : $urandom_range(0, 2)),
           TAG_W'($urandom));
  endtask

  // One cycle: drive after the edge, check and update model before the next.
  task automatic step(logic [1:0] v, logic rdy);
    logic [1:0] exp_rdy;
    bit         slot;
    bit         win;
    @(posedge clk);
    #1;
    req_valid = v;
    o_ready   = rdy;
    for (int i = 0; i < 2; i++) begin
      req_data1[64*i +: 64]       = A[i];
      req_data2[64*i +: 64]       = B[i];
      req_fmt[2*i +: 2]           = F[i];
      req_rm[3*i +: 3]            = R[i];
      req_tag[TAG_W*i +: TAG_W]   = T[i];
    end
    @(negedge clk);
    chk("o_valid", 64'(o_valid), 64'(m_valid));
    slot    = !m_valid || rdy;
    win     = (v == 2'b11) ? m_ptr : v[1];
    exp_rdy = (v != 0 && slot) ? (win ? 2'b10 : 2'b01) : 2'b00;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (exp_rdy != 0) begin
      sb.push_back(ref_op(A[win], B[win], F[win], R[win], T[win], win));
      m_cnt[win] = (m_cnt[win] + 1) % (1 << CNT_W);
      m_ptr      = !win;
      m_valid    = 1'b1;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic chk_cnt();
    chk("cnt0", 64'(cnt0), 64'(m_cnt[0]));
    chk("cnt1", 64'(cnt1), 64'(m_cnt[1]));
  endtask

  task automatic model_reset();
    sb.delete();
    m_valid  = 1'b0;
    m_ptr    = 1'b0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  // Monitor: every consumed result must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && o_valid && o_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got %h want none", o_result);
      end else begin
        e = sb.pop_front();
        chk("o_result", o_result, e.res);
        chk("o_tag", 64'(o_tag), 64'(e.tag));
        chk("o_src", 64'(o_src), 64'(e.src));
        chk("o_err", 64'(o_err), 64'(e.err));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    o_ready   = 1'b0;
    req_data1 = '0;
    req_data2 = '0;
    req_fmt   = '0;
    req_rm    = '0;
    req_tag   = '0;
    for (int i = 0; i < 2; i++) set_op(i, 64'h0, 64'h0, 2'd0, 3'd0, '0);
    model_reset();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_valid", 64'(o_valid), 64'h0);
    chk("rst_o_result", o_result, 64'h0);
    chk("rst_o_tag", 64'(o_tag), 64'h0);
    chk("rst_o_src_err", 64'({o_src, o_err}), 64'h0);
    chk_cnt();
    @(negedge clk);
    rst_n = 1'b1;

    // Req0 F32 SGNJ
    set_op(0, 64'h3F800000, 64'h80000000, 2'd0, 3'd0, 4'd5);
    step(2'b01, 1'b1);
    step(2'b00, 1'b1);
    chk("t2_result", o_result, 64'h00000000BF800000);
    chk_cnt();

    // Req1 F64 SGNJX
    set_op(1, 64'hC000000000000000, 64'h8000000000000000, 2'd1, 3'd2, 4'd9);
    step(2'b10, 1'b1);
    step(2'b00, 1'b1);
    chk("t4_result", o_result, 64'h4000000000000000);

    // Both valid, alternating grants
    for (int k = 0; k < 6; k++) begin
      rand_op(0);
      rand_op(1);
      step(2'b11, 1'b1);
    end
    step(2'b00, 1'b1);
    chk_cnt();

    // Back-pressure with both valid, then drain+accept in one edge
    rand_op(0);
    rand_op(1);
    step(2'b11, 1'b1);
    repeat (3) step(2'b11, 1'b0);
    step(2'b11, 1'b1);
    step(2'b00, 1'b1);

    // Illegal fmt and illegal rm
    set_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 2'd2, 3'd0, 4'd3);
    step(2'b01, 1'b1);
    step(2'b00, 1'b1);
    chk("t6_fmt_res", o_result, 64'h0);
    chk("t6_fmt_err", 64'(o_err), 64'h1);
    set_op(1, 64'h00000000C0490FDB, 64'h80000000, 2'd0, 3'd3, 4'd4);
    step(2'b10, 1'b1);
    step(2'b00, 1'b1);
    chk("t6_rm_res", o_result, 64'h0000000040490FDB);
    chk("t6_rm_err", 64'(o_err), 64'h1);

    // Counter wrap on requester 0
    while (m_cnt[0] != (1 << CNT_W) - 1) begin
      rand_op(0);
      step(2'b01, 1'b1);
    end
    step(2'b00, 1'b1);
    chk_cnt();
    rand_op(0);
    step(2'b01, 1'b1);
    step(2'b00, 1'b1);
    chk("cnt0_wrap", 64'(cnt0), 64'h0);

    // Async reset while stalled with a held result
    rand_op(0);
    rand_op(1);
    step(2'b11, 1'b0);
    step(2'b11, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_o_valid", 64'(o_valid), 64'h0);
    chk("arst_cnt", 64'({cnt0, cnt1}), 64'h0);
    chk("arst_req_ready", 64'(req_ready), 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    chk("arst_hold_ready", 64'(req_ready), 64'h0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // ptr back at 0: contention goes to requester 0 first
    step(2'b11, 1'b1);
    step(2'b00, 1'b1);
    chk("arst_ptr_src", 64'(o_src), 64'h0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      rand_op(0);
      rand_op(1);
      step(2'($urandom), ($urandom_range(0, 3) != 0));
    end
    repeat (3) step(2'b00, 1'b1);
    chk_cnt();
    #1;
    chk("sb_empty", 64'(sb.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
